// File: rtl/rle_pkg.sv
// Shared definitions for the 8-coefficient run-length encoder.
// Holds the default geometry constants, the FSM state type and the token record.
package rle_pkg;

    localparam int unsigned N      = 8;   // coefficients per block
    localparam int unsigned COEF_W = 18;  // signed DCT coefficient width
    localparam int unsigned QSHIFT = 4;   // quantization right-shift
    localparam int unsigned VAL_W  = 12;  // signed quantized value width
    localparam int unsigned RUN_W  = 3;   // clog2(N)

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EOB
    } state_t;

    typedef struct packed {
        logic [RUN_W-1:0]        run;
        logic signed [VAL_W-1:0] value;
        logic                    eob;
    } rle_tok_t;

endpackage

// File: rtl/rle_encoder_8_if.sv
// Stream bundle around the run-length encoder.
//   blk_valid/blk_ready/coef_in          : coefficient block input handshake
//   out_valid/out_ready/out_run/
//   out_value/out_eob                    : token output handshake
// Modport slave is the encoder side, master is the block source / token sink.
interface rle_encoder_8_if;
    import rle_pkg::*;

    logic                    blk_valid;
    logic                    blk_ready;
    logic [N*COEF_W-1:0]     coef_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [RUN_W-1:0]        out_run;
    logic signed [VAL_W-1:0] out_value;
    logic                    out_eob;

    modport slave (
        input  blk_valid,
        output blk_ready,
        input  coef_in,
        output out_valid,
        input  out_ready,
        output out_run,
        output out_value,
        output out_eob
    );

    modport master (
        output blk_valid,
        input  blk_ready,
        output coef_in,
        input  out_valid,
        output out_ready,
        input  out_run,
        input  out_value,
        input  out_eob
    );

endinterface

// File: rtl/coef_quant.sv
// Combinational coefficient quantizer: arithmetic right shift (floor) followed
// by saturation into a signed VAL_W result.
//   coef : signed COEF_W input coefficient
//   q    : signed VAL_W quantized value
module coef_quant #(
    parameter int unsigned COEF_W = 18,
    parameter int unsigned QSHIFT = 4,
    parameter int unsigned VAL_W  = 12
) (
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [VAL_W-1:0]  q
);

    // Saturation bounds expressed at the input width; ~MAXV is -2^(VAL_W-1).
    localparam logic signed [COEF_W-1:0] MAXV = COEF_W'((1 << (VAL_W - 1)) - 1);
    localparam logic signed [COEF_W-1:0] MINV = ~MAXV;

    logic signed [COEF_W-1:0] sh;

    always_comb begin
        sh = coef >>> QSHIFT;
        if (sh > MAXV) begin
            q = MAXV[VAL_W-1:0];
        end else if (sh < MINV) begin
            q = MINV[VAL_W-1:0];
        end else begin
            q = sh[VAL_W-1:0];
        end
    end

endmodule

// File: rtl/rle_encoder_8.sv
// Run-length encoder for one 8-coefficient DCT block per handshake.
// Quantizes all coefficients at acceptance, then scans them in index order,
// emitting a (zero-run, value) token per non-zero value and a final EOB token.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of rle_encoder_8_if (block input and token output)
module rle_encoder_8
    import rle_pkg::*;
(
    input logic           clk,
    input logic           reset,
    rle_encoder_8_if.slave bus
);

    localparam logic [RUN_W-1:0] LAST = RUN_W'(N - 1);

    state_t                  state_q, state_d;
    logic [RUN_W-1:0]        idx_q, idx_d;
    logic [RUN_W-1:0]        run_q, run_d;
    logic signed [VAL_W-1:0] q_d [N];
    logic signed [VAL_W-1:0] q_q [N];
    logic                    load;
    logic signed [VAL_W-1:0] cur;
    logic                    cur_nz;
    logic                    last;
    rle_tok_t                tok;

    for (genvar i = 0; i < N; i++) begin : g_quant
        coef_quant #(
            .COEF_W(COEF_W),
            .QSHIFT(QSHIFT),
            .VAL_W (VAL_W)
        ) u_quant (
            .coef(bus.coef_in[i*COEF_W +: COEF_W]),
            .q   (q_d[i])
        );
    end

    assign cur    = q_q[idx_q];
    assign cur_nz = (cur != '0);
    assign last   = (idx_q == LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: quantized block, scan index and zero-run counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            run_q <= '0;
            for (int i = 0; i < N; i++) begin
                q_q[i] <= '0;
            end
        end else begin
            idx_q <= idx_d;
            run_q <= run_d;
            if (load) begin
                for (int i = 0; i < N; i++) begin
                    q_q[i] <= q_d[i];
                end
            end
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        run_d   = run_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.blk_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    run_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!cur_nz) begin
                    if (last) begin
                        // Trailing zeros are implicit: no token, straight to EOB.
                        idx_d   = '0;
                        run_d   = '0;
                        state_d = EOB;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        run_d = run_q + 1'b1;
                    end
                end else if (bus.out_ready) begin
                    run_d = '0;
                    if (last) begin
                        idx_d   = '0;
                        state_d = EOB;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            EOB: begin
                run_d = '0;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        tok           = '0;
        bus.out_valid = 1'b0;
        bus.blk_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.blk_ready = 1'b1;
            end
            SCAN: begin
                if (cur_nz) begin
                    bus.out_valid = 1'b1;
                    tok.run       = run_q;
                    tok.value     = cur;
                end
            end
            EOB: begin
                bus.out_valid = 1'b1;
                tok.eob       = 1'b1;
            end
            default: begin
                bus.blk_ready = 1'b0;
            end
        endcase
    end

    assign bus.out_run   = tok.run;
    assign bus.out_value = tok.value;
    assign bus.out_eob   = tok.eob;

endmodule

// File: tb/tb_rle_encoder_8.sv
module tb_rle_encoder_8;
    import rle_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rle_encoder_8_if tif();

    rle_encoder_8 dut (
        .clk  (clk),
        .reset(reset),
        .bus  (tif.slave)
    );

    typedef struct packed {
        logic [N-1:0][COEF_W-1:0] coef;
        logic [1:0]               mode;     // 0 ready high, 1 low cycles 1-3, 2 toggling
        logic [3:0]               ntok;
        logic [N-1:0][RUN_W-1:0]  run;
        logic [N-1:0][VAL_W-1:0]  val;
        logic [5:0]               eob_cyc;
    } vec_t;

    vec_t vecs [5];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            1:       return !(c >= 1 && c <= 3);
            2:       return (c % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    // Applies one block at acceptance edge 0; cycle c is sampled at the negedge after edge c-1.
    task automatic run_block(input int v);
        int   c, nobs, eobc, ready_bad, stab_bad, eob_run, eob_val;
        bit   done, holding;
        int   obs_run [16];
        int   obs_val [16];
        logic [RUN_W-1:0] hr;
        logic [VAL_W-1:0] hv;
        logic             he;
        c = 1; nobs = 0; eobc = -1; ready_bad = 0; stab_bad = 0;
        eob_run = -1; eob_val = -1; done = 0; holding = 0;
        hr = '0; hv = '0; he = 1'b0;
        for (int i = 0; i < 16; i++) begin
            obs_run[i] = 0;
            obs_val[i] = 0;
        end
        @(negedge clk);
        check($sformatf("v%0d_idle_ready", v), int'(tif.blk_ready), 1);
        tif.coef_in   = vecs[v].coef;
        tif.blk_valid = 1'b1;
        tif.out_ready = 1'b1;
        @(posedge clk);
        while (!done && c < 40) begin
            @(negedge clk);
            tif.blk_valid = 1'b0;
            tif.out_ready = rdy(int'(vecs[v].mode), c);
            if (tif.blk_ready) ready_bad++;
            if (tif.out_valid) begin
                if (holding && (tif.out_run != hr || tif.out_value != hv || tif.out_eob != he))
                    stab_bad++;
                if (tif.out_eob) begin
                    if (!holding) begin
                        eobc    = c;
                        eob_run = int'(tif.out_run);
                        eob_val = int'($signed(tif.out_value));
                    end
                    if (tif.out_ready) done = 1;
                end else if (!holding && nobs < 16) begin
                    obs_run[nobs] = int'(tif.out_run);
                    obs_val[nobs] = int'($signed(tif.out_value));
                    nobs++;
                end
                holding = !tif.out_ready;
                hr = tif.out_run; hv = tif.out_value; he = tif.out_eob;
            end else begin
                holding = 0;
            end
            c++;
        end
        if (!done) check($sformatf("v%0d_timeout", v), 0, 1);
        check($sformatf("v%0d_ntok", v), nobs, int'(vecs[v].ntok));
        for (int i = 0; i < int'(vecs[v].ntok); i++) begin
            check($sformatf("v%0d_tok%0d_run", v, i), obs_run[i], int'(vecs[v].run[i]));
            check($sformatf("v%0d_tok%0d_val", v, i), obs_val[i],
                  int'($signed(vecs[v].val[i])));
        end
        check($sformatf("v%0d_eob_cycle", v), eobc, int'(vecs[v].eob_cyc));
        check($sformatf("v%0d_eob_run", v), eob_run, 0);
        check($sformatf("v%0d_eob_val", v), eob_val, 0);
        check($sformatf("v%0d_ready_busy", v), ready_bad, 0);
        check($sformatf("v%0d_stable", v), stab_bad, 0);
        @(negedge clk);
        check($sformatf("v%0d_ready_after", v), int'(tif.blk_ready), 1);
        check($sformatf("v%0d_valid_after", v), int'(tif.out_valid), 0);
    endtask

    initial begin
        int  last, acc, bad;
        bit  found;

        for (int i = 0; i < 5; i++) vecs[i] = '0;
        // All coefficients 15 -> quantize to 0.
        for (int i = 0; i < N; i++) vecs[0].coef[i] = 18'd15;
        vecs[0].eob_cyc = 6'd9;
        // Sparse block [64,0,0,-32,0,0,0,16].
        vecs[1].coef[0] = 18'd64;
        vecs[1].coef[3] = 18'h3FFE0;
        vecs[1].coef[7] = 18'd16;
        vecs[1].ntok = 4'd3;
        vecs[1].run[0] = 3'd0; vecs[1].val[0] = 12'd4;
        vecs[1].run[1] = 3'd2; vecs[1].val[1] = 12'hFFE;
        vecs[1].run[2] = 3'd3; vecs[1].val[2] = 12'd1;
        vecs[1].eob_cyc = 6'd9;
        // Saturation and floor rounding.
        vecs[2].coef[0] = 18'h1FFFF;
        vecs[2].coef[1] = 18'h20000;
        vecs[2].coef[2] = 18'h3FFFF;
        vecs[2].coef[3] = 18'd15;
        vecs[2].coef[4] = 18'd16;
        vecs[2].ntok = 4'd4;
        vecs[2].run[0] = 3'd0; vecs[2].val[0] = 12'd2047;
        vecs[2].run[1] = 3'd0; vecs[2].val[1] = 12'h800;
        vecs[2].run[2] = 3'd0; vecs[2].val[2] = 12'hFFF;
        vecs[2].run[3] = 3'd1; vecs[2].val[3] = 12'd1;
        vecs[2].eob_cyc = 6'd9;
        // Sparse with 3 stall cycles on the first token, then with toggling ready.
        vecs[3] = vecs[1]; vecs[3].mode = 2'd1; vecs[3].eob_cyc = 6'd12;
        vecs[4] = vecs[1]; vecs[4].mode = 2'd2; vecs[4].eob_cyc = 6'd11;

        tif.blk_valid = 1'b0;
        tif.coef_in   = '0;
        tif.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", int'(tif.out_valid), 0);
        check("rst_eob", int'(tif.out_eob), 0);
        check("rst_run", int'(tif.out_run), 0);
        check("rst_value", int'(tif.out_value), 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready_after", int'(tif.blk_ready), 1);

        for (int v = 0; v < 5; v++) run_block(v);

        // blk_valid held high: one acceptance every N+2 cycles.
        @(negedge clk);
        for (int i = 0; i < N; i++) tif.coef_in[i*COEF_W +: COEF_W] = 18'd15;
        tif.blk_valid = 1'b1;
        tif.out_ready = 1'b1;
        @(posedge clk);
        last = 0; acc = 0; bad = 0;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (tif.blk_ready) begin
                if (c - last != N + 2) bad++;
                if (tif.out_valid) bad++;
                last = c;
                acc++;
            end
        end
        tif.blk_valid = 1'b0;
        check("cont_accepts", acc, 3);
        check("cont_spacing", bad, 0);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (tif.blk_ready) found = 1;
        end
        check("cont_drain", int'(found), 1);

        // Reset while (2,-2) is pending.
        tif.coef_in   = vecs[1].coef;
        tif.blk_valid = 1'b1;
        tif.out_ready = 1'b1;
        @(posedge clk);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            tif.blk_valid = 1'b0;
            if (tif.out_valid && !tif.out_eob && tif.out_run == 3'd2) found = 1;
        end
        check("mid_found", int'(found), 1);
        reset = 1'b0;
        #1;
        check("mid_valid_async", int'(tif.out_valid), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_ready", int'(tif.blk_ready), 1);
        check("mid_valid", int'(tif.out_valid), 0);
        run_block(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
